bullcow_turn_ctrl: RTL and testbench

BULLCOW_TURN_CTRL -- requirements
Module: bullcow_turn_ctrl

---
 rtl/bullcow_turn_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_bullcow_turn_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullcow_turn_ctrl.sv
// Two-player Bulls & Cows turn controller: secret entry, alternating guesses,
// external scoring handshake, round/match bookkeeping.
module bullcow_turn_ctrl #(
    parameter int unsigned ROUNDS_TO_WIN = 3,
    parameter int unsigned END_HOLD      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enter,
    input  logic [15:0] sw,
    output logic        chk_start,
    output logic [15:0] chk_secret,
    output logic [15:0] chk_guess,
    input  logic        chk_done,
    input  logic [2:0]  chk_bulls,
    input  logic [2:0]  chk_cows,
    output logic [2:0]  phase,
    output logic        player,
    output logic        err,
    output logic [2:0]  last_bulls,
    output logic [2:0]  last_cows,
    output logic [7:0]  guess_cnt,
    output logic [7:0]  points_p1,
    output logic [7:0]  points_p2
);

    typedef enum logic [2:0] {
        S1_SETUP   = 3'd0,
        S2_SETUP   = 3'd1,
        P1_GUESS   = 3'd2,
        P2_GUESS   = 3'd3,
        CHECK      = 3'd4,
        END_ROUND  = 3'd5,
        MATCH_OVER = 3'd6
    } state_t;

    localparam int unsigned HOLD_W = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;

    state_t              state_q, state_d;
    logic                enter_q, press;
    logic                starter_q, guesser_q;
    logic [15:0]         secret1_q, secret2_q, guess_q;
    logic [2:0]          bulls_q, cows_q;
    logic [7:0]          gcnt_q, pts1_q, pts2_q, winner_pts;
    logic [HOLD_W-1:0]   hold_q;
    logic                hold_done;
    logic                err_q, chk_start_q;
    logic                store_s1, store_s2, take_guess, bad_entry;
    logic                score, win, round_clr, match_clr;

    function automatic logic entry_ok(input logic [15:0] v);
        logic       ok;
        logic [3:0] d [4];
        ok = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            d[i] = v[4*i +: 4];
            if (d[i] > 4'd9) ok = 1'b0;
        end
        for (int unsigned i = 0; i < 4; i++)
            for (int unsigned j = i + 1; j < 4; j++)
                if (d[i] == d[j]) ok = 1'b0;
        return ok;
    endfunction

    assign press      = enter & ~enter_q;
    assign hold_done  = (hold_q == HOLD_W'(END_HOLD - 1));
    assign winner_pts = guesser_q ? pts2_q : pts1_q;

    always_comb begin
        state_d    = state_q;
        store_s1   = 1'b0;
        store_s2   = 1'b0;
        take_guess = 1'b0;
        bad_entry  = 1'b0;
        score      = 1'b0;
        win        = 1'b0;
        round_clr  = 1'b0;
        match_clr  = 1'b0;
        case (state_q)
            S1_SETUP: if (press) begin
                if (entry_ok(sw)) begin
                    store_s1 = 1'b1;
                    state_d  = S2_SETUP;
                end else bad_entry = 1'b1;
            end
            S2_SETUP: if (press) begin
                if (entry_ok(sw)) begin
                    store_s2 = 1'b1;
                    state_d  = starter_q ? P2_GUESS : P1_GUESS;
                end else bad_entry = 1'b1;
            end
            P1_GUESS, P2_GUESS: if (press) begin
                if (entry_ok(sw)) begin
                    take_guess = 1'b1;
                    state_d    = CHECK;
                end else bad_entry = 1'b1;
            end
            CHECK: if (chk_done) begin
                score = 1'b1;
                if (chk_bulls == 3'd4) begin
                    win     = 1'b1;
                    state_d = END_ROUND;
                end else begin
                    state_d = guesser_q ? P1_GUESS : P2_GUESS;
                end
            end
            // winner_pts already includes the point awarded on entry
            END_ROUND: if (hold_done) begin
                if (winner_pts == 8'(ROUNDS_TO_WIN)) state_d = MATCH_OVER;
                else begin
                    state_d   = S1_SETUP;
                    round_clr = 1'b1;
                end
            end
            MATCH_OVER: if (press) begin
                match_clr = 1'b1;
                state_d   = S1_SETUP;
            end
            default: state_d = S1_SETUP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S1_SETUP;
            enter_q     <= 1'b0;
            starter_q   <= 1'b0;
            guesser_q   <= 1'b0;
            secret1_q   <= '0;
            secret2_q   <= '0;
            guess_q     <= '0;
            bulls_q     <= '0;
            cows_q      <= '0;
            gcnt_q      <= '0;
            pts1_q      <= '0;
            pts2_q      <= '0;
            hold_q      <= '0;
            err_q       <= 1'b0;
            chk_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            enter_q     <= enter;
            err_q       <= bad_entry;
            chk_start_q <= take_guess;
            if (store_s1) secret1_q <= sw;
            if (store_s2) secret2_q <= sw;
            if (take_guess) begin
                guess_q   <= sw;
                guesser_q <= (state_q == P2_GUESS);
                if (gcnt_q != 8'hFF) gcnt_q <= gcnt_q + 8'd1;
            end
            if (score) begin
                bulls_q <= chk_bulls;
                cows_q  <= chk_cows;
            end
            if (win) begin
                if (guesser_q) begin
                    if (pts2_q != 8'hFF) pts2_q <= pts2_q + 8'd1;
                end else begin
                    if (pts1_q != 8'hFF) pts1_q <= pts1_q + 8'd1;
                end
            end
            if (state_q != END_ROUND) hold_q <= '0;
            else if (!hold_done)      hold_q <= hold_q + HOLD_W'(1);
            if (state_q == END_ROUND && hold_done) starter_q <= ~starter_q;
            if (round_clr || match_clr) begin
                secret1_q <= '0;
                secret2_q <= '0;
                gcnt_q    <= '0;
                bulls_q   <= '0;
                cows_q    <= '0;
            end
            if (match_clr) begin
                pts1_q    <= '0;
                pts2_q    <= '0;
                starter_q <= 1'b0;
                guesser_q <= 1'b0;
            end
        end
    end

    always_comb begin
        player = 1'b0;
        case (state_q)
            S1_SETUP:                      player = 1'b0;
            S2_SETUP:                      player = 1'b1;
            P1_GUESS:                      player = 1'b0;
            P2_GUESS:                      player = 1'b1;
            CHECK, END_ROUND, MATCH_OVER:  player = guesser_q;
            default:                       player = 1'b0;
        endcase
    end

    // P2 guesses against secret1, P1 against secret2; in CHECK the latched guesser selects
    assign chk_secret = (state_q == P2_GUESS) ? secret1_q :
                        (state_q == P1_GUESS) ? secret2_q :
                        (guesser_q ? secret1_q : secret2_q);
    assign chk_guess  = guess_q;
    assign chk_start  = chk_start_q;
    assign phase      = state_q;
    assign err        = err_q;
    assign last_bulls = bulls_q;
    assign last_cows  = cows_q;
    assign guess_cnt  = gcnt_q;
    assign points_p1  = pts1_q;
    assign points_p2  = pts2_q;

endmodule

// File: tb/tb_bullcow_turn_ctrl.sv
// Bench for bullcow_turn_ctrl: entry-validity table, scoreboarded scorer
// responses, and hand sequences for hold, round end, match end and reset.
module tb_bullcow_turn_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enter = 1'b0;
    logic [15:0] sw = '0;
    logic        chk_done = 1'b0;
    logic [2:0]  chk_bulls = '0;
    logic [2:0]  chk_cows = '0;

    logic        a_chk_start, a_player, a_err;
    logic [15:0] a_chk_secret, a_chk_guess;
    logic [2:0]  a_phase, a_last_bulls, a_last_cows;
    logic [7:0]  a_guess_cnt, a_points_p1, a_points_p2;

    logic        b_chk_start, b_player, b_err;
    logic [15:0] b_chk_secret, b_chk_guess;
    logic [2:0]  b_phase, b_last_bulls, b_last_cows;
    logic [7:0]  b_guess_cnt, b_points_p1, b_points_p2;

    bullcow_turn_ctrl u_dut (
        .clock(clock), .reset(reset), .enter(enter), .sw(sw),
        .chk_start(a_chk_start), .chk_secret(a_chk_secret), .chk_guess(a_chk_guess),
        .chk_done(chk_done), .chk_bulls(chk_bulls), .chk_cows(chk_cows),
        .phase(a_phase), .player(a_player), .err(a_err),
        .last_bulls(a_last_bulls), .last_cows(a_last_cows), .guess_cnt(a_guess_cnt),
        .points_p1(a_points_p1), .points_p2(a_points_p2)
    );

    bullcow_turn_ctrl #(.ROUNDS_TO_WIN(1), .END_HOLD(2)) u_win1 (
        .clock(clock), .reset(reset), .enter(enter), .sw(sw),
        .chk_start(b_chk_start), .chk_secret(b_chk_secret), .chk_guess(b_chk_guess),
        .chk_done(chk_done), .chk_bulls(chk_bulls), .chk_cows(chk_cows),
        .phase(b_phase), .player(b_player), .err(b_err),
        .last_bulls(b_last_bulls), .last_cows(b_last_cows), .guess_cnt(b_guess_cnt),
        .points_p1(b_points_p1), .points_p2(b_points_p2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] sw;
        logic        exp_err;
        logic [2:0]  exp_phase;
    } vec_t;

    typedef struct {
        logic [2:0] phase;
        logic       player;
        logic [2:0] bulls;
        logic [2:0] cows;
        logic [7:0] gcnt;
        logic [7:0] p1;
        logic [7:0] p2;
    } exp_t;

    vec_t        vecs [7];
    exp_t        sbq [$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        enter    = 1'b0;
        chk_done = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // drives a one-edge press; outputs are sampled by the caller before the next tick
    task automatic press_on(input logic [15:0] v);
        sw    = v;
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic score_and_check(input logic [2:0] b, input logic [2:0] c, input exp_t e);
        exp_t g;
        sbq.push_back(e);
        chk_done  = 1'b1;
        chk_bulls = b;
        chk_cows  = c;
        tick();
        chk_done = 1'b0;
        g = sbq.pop_front();
        check("sb_phase",  a_phase,      g.phase);
        check("sb_player", a_player,     g.player);
        check("sb_bulls",  a_last_bulls, g.bulls);
        check("sb_cows",   a_last_cows,  g.cows);
        check("sb_gcnt",   a_guess_cnt,  g.gcnt);
        check("sb_p1",     a_points_p1,  g.p1);
        check("sb_p2",     a_points_p2,  g.p2);
    endtask

    initial begin
        int n;
        vecs[0] = '{16'h1123, 1'b1, 3'd0};
        vecs[1] = '{16'h1A23, 1'b1, 3'd0};
        vecs[2] = '{16'hF321, 1'b1, 3'd0};
        vecs[3] = '{16'h0000, 1'b1, 3'd0};
        vecs[4] = '{16'h9879, 1'b1, 3'd0};
        vecs[5] = '{16'h4321, 1'b0, 3'd1};
        vecs[6] = '{16'h0987, 1'b0, 3'd1};

        // reset state
        do_reset();
        check("rst_phase",   a_phase,      0);
        check("rst_player",  a_player,     0);
        check("rst_err",     a_err,        0);
        check("rst_start",   a_chk_start,  0);
        check("rst_gcnt",    a_guess_cnt,  0);
        check("rst_pts",     a_points_p1 + a_points_p2, 0);
        check("rst_secret",  a_chk_secret, 0);
        check("rst_guess",   a_chk_guess,  0);

        // entry validity in S1_SETUP
        for (int i = 0; i < 7; i++) begin
            do_reset();
            press_on(vecs[i].sw);
            check("tbl_err",   a_err,   vecs[i].exp_err);
            check("tbl_phase", a_phase, vecs[i].exp_phase);
            tick();
            check("tbl_err_gone", a_err, 0);
        end

        // main round: setup errors, P1 miss, P2 win in first CHECK cycle
        do_reset();
        press_on(16'h1123);
        check("s1_err", a_err, 1);
        check("s1_stay", a_phase, 0);
        tick();
        check("s1_err_1cyc", a_err, 0);
        press_on(16'h1234);
        check("s2_phase", a_phase, 1);
        check("s2_player", a_player, 1);
        tick();
        press_on(16'h1A23);
        check("s2_err", a_err, 1);
        check("s2_stay", a_phase, 1);
        tick();
        press_on(16'h5678);
        check("p1_phase", a_phase, 2);
        check("p1_player", a_player, 0);
        tick();
        chk_done  = 1'b1;
        chk_bulls = 3'd4;
        tick();
        chk_done = 1'b0;
        check("done_ignored_phase", a_phase, 2);
        check("done_ignored_bulls", a_last_bulls, 0);
        press_on(16'h1123);
        check("p1_err", a_err, 1);
        check("p1_gcnt_keep", a_guess_cnt, 0);
        tick();
        press_on(16'h8765);
        check("chk_phase", a_phase, 4);
        check("chk_start", a_chk_start, 1);
        check("chk_secret_p1", a_chk_secret, 16'h5678);
        check("chk_guess_p1", a_chk_guess, 16'h8765);
        check("chk_gcnt1", a_guess_cnt, 1);
        tick();
        check("chk_start_1cyc", a_chk_start, 0);
        sw    = 16'h0123;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        check("chk_press_ignored", a_phase, 4);
        check("chk_secret_hold", a_chk_secret, 16'h5678);
        check("chk_guess_hold", a_chk_guess, 16'h8765);
        score_and_check(3'd0, 3'd4, '{3'd3, 1'b1, 3'd0, 3'd4, 8'd1, 8'd0, 8'd0});
        press_on(16'h1234);
        check("chk_phase_p2", a_phase, 4);
        check("chk_start_p2", a_chk_start, 1);
        check("chk_secret_p2", a_chk_secret, 16'h1234);
        score_and_check(3'd4, 3'd0, '{3'd5, 1'b1, 3'd4, 3'd0, 8'd2, 8'd0, 8'd1});
        n = 1;
        while (a_phase == 3'd5 && n < 50) begin
            tick();
            if (a_phase == 3'd5) n++;
        end
        check("end_hold_cycles", n, 4);
        check("next_round_phase", a_phase, 0);
        check("next_round_gcnt", a_guess_cnt, 0);
        check("next_round_last", a_last_bulls + a_last_cows, 0);
        check("next_round_p2", a_points_p2, 1);
        press_on(16'h2345);
        tick();
        press_on(16'h6789);
        check("starter_alt_phase", a_phase, 3);
        check("starter_alt_player", a_player, 1);
        check("starter_alt_secret", a_chk_secret, 16'h2345);
        tick();

        // held enter counts once
        do_reset();
        sw    = 16'h1234;
        enter = 1'b1;
        repeat (10) tick();
        enter = 1'b0;
        tick();
        check("hold_once", a_phase, 1);

        // match end with ROUNDS_TO_WIN=1
        do_reset();
        press_on(16'h1234);
        tick();
        press_on(16'h5678);
        tick();
        press_on(16'h5678);
        check("w1_check", b_phase, 4);
        chk_done  = 1'b1;
        chk_bulls = 3'd4;
        chk_cows  = 3'd0;
        tick();
        chk_done = 1'b0;
        check("w1_end", b_phase, 5);
        check("w1_pts", b_points_p1, 1);
        n = 0;
        while (b_phase == 3'd5 && n < 20) begin
            tick();
            n++;
        end
        check("w1_match_over", b_phase, 6);
        check("w1_player", b_player, 0);
        tick();
        tick();
        check("w1_stay_over", b_phase, 6);
        press_on(16'h0000);
        check("w1_restart", b_phase, 0);
        check("w1_pts_clr", b_points_p1, 0);
        check("w1_no_err", b_err, 0);
        tick();

        // reset abandons a pending score
        do_reset();
        press_on(16'h1234);
        tick();
        press_on(16'h5678);
        tick();
        press_on(16'h8765);
        check("mid_chk_phase", a_phase, 4);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_phase", a_phase, 0);
        check("mid_rst_outs", a_chk_start + a_player + a_err + a_last_bulls + a_last_cows, 0);
        check("mid_rst_data", a_chk_secret + a_chk_guess + a_guess_cnt + a_points_p1 + a_points_p2, 0);
        chk_done  = 1'b1;
        chk_bulls = 3'd4;
        tick();
        chk_done = 1'b0;
        tick();
        check("late_done_phase", a_phase, 0);
        check("late_done_data", a_points_p1 + a_last_bulls, 0);
        check("sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
